conv_encoder_stream: RTL

- Rate-1/2 feedforward convolutional encoder.
- Generates the coded symbol pairs that the Viterbi decoder datapath (ACS / path-metric mux stages) consumes. It is the transmit end of the same channel.
- Accepts one information bit per handshake and emits one 2-bit symbol per handshake.
- On frame end it appends K-1 zero tail bits, so the decoder's trellis terminates in state 0.

---
 rtl/conv_encoder_stream.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/conv_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder_stream
// Purpose  : Rate-1/2 feedforward convolutional encoder with valid/ready
//            streaming on both sides. One information bit in per handshake,
//            one 2-bit coded symbol out per handshake. At frame end K-1 zero
//            tail bits are appended so the receiving trellis ends in state 0.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            in_valid/in_ready   - input handshake
//            in_bit, in_last     - information bit, last bit of frame
//            out_valid/out_ready - output handshake
//            out_sym             - {g1 parity, g0 parity}
//            out_last            - final tail symbol of the frame
//            sym_count           - symbols of this frame incl. current transfer
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_stream #(
   parameter int           K     = 3,
   parameter logic [K-1:0] G0    = 3'b111,
   parameter logic [K-1:0] G1    = 3'b101,
   parameter int           CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [1:0]       out_sym,
   output logic             out_last,
   input  logic             out_ready,
   output logic [CNT_W-1:0] sym_count
);

   localparam int TW = $clog2(K) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [K-2:0]     sr;
   logic [TW-1:0]    tail_cnt;
   logic [CNT_W-1:0] cnt;

   logic             slot_free;
   logic             in_fire;
   logic             out_fire;
   logic             flush_load;
   logic             tail_done;
   logic             load;
   logic [K-1:0]     r;

   // The output slot can take a new symbol when empty or draining this cycle.
   assign slot_free  = !out_valid || out_ready;
   assign in_ready   = ((state == IDLE) || (state == DATA)) && slot_free;
   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign flush_load = (state == FLUSH) && slot_free;
   assign tail_done  = (tail_cnt == TW'(K - 2));
   assign load       = in_fire || flush_load;

   // Tail bits are zeros: in FLUSH in_fire is 0, so the new bit is 0.
   assign r = {in_fire ? in_bit : 1'b0, sr};

   // sym_count counts the handshake happening this cycle as well.
   assign sym_count = (out_fire && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_fire) begin
               state_next = in_last ? FLUSH : DATA;
            end
         end
         DATA: begin
            if (in_fire && in_last) begin
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_load && tail_done) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (out_fire && out_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shift state and tail counter. After the last tail bit sr is already 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr       <= '0;
         tail_cnt <= '0;
      end else begin
         if (load) begin
            sr <= r[K-1:1];
         end
         if (flush_load) begin
            tail_cnt <= tail_done ? '0 : tail_cnt + TW'(1);
         end
      end
   end

   // Single-entry output register; holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sym   <= 2'b00;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_sym   <= {^(r & G1), ^(r & G0)};
         out_last  <= flush_load && tail_done;
      end else if (out_fire) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   // Completed handshakes of the current frame; cleared after out_last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (out_fire) begin
         cnt <= out_last ? '0 : sym_count;
      end
   end

endmodule
`default_nettype wire
